// File: rtl/sap1_prog_loader.sv
// SAP-1 program loader: strobed byte stream into RAM, holds then resets the core.
// Define LOADER_CHECKSUM_EN to add the o_checksum session-sum output.
module sap1_prog_loader #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_en,
  input  logic              i_strobe,
  input  logic [DATA_W-1:0] i_data_in,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_cpu_rst,
  output logic              o_load_done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] o_checksum
`endif
);

  typedef enum logic [2:0] {
    RUN,
    ARM,
    WRITE,
    DRAIN,
    RELEASE
  } state_t;

  state_t r_state;

  logic [SYNC_STAGES-1:0] r_ld_sync;
  logic [SYNC_STAGES-1:0] r_st_sync;
  logic                   r_st_d;
  logic                   r_edge;
  logic [ADDR_W-1:0]      r_cnt;

  logic w_ld;
  logic w_st;

  assign w_ld = r_ld_sync[SYNC_STAGES-1];
  assign w_st = r_st_sync[SYNC_STAGES-1];

  // Edge pulse is registered so every output stays a flop output.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ld_sync <= '0;
      r_st_sync <= '0;
      r_st_d    <= 1'b0;
      r_edge    <= 1'b0;
    end else begin
      r_ld_sync <= {r_ld_sync[SYNC_STAGES-2:0], i_load_en};
      r_st_sync <= {r_st_sync[SYNC_STAGES-2:0], i_strobe};
      r_st_d    <= w_st;
      r_edge    <= w_st & ~r_st_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_cpu_hold  <= 1'b0;
      o_cpu_rst   <= 1'b0;
      o_load_done <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      o_checksum  <= '0;
`endif
    end else begin
      unique case (r_state)
        RUN: begin
          o_cpu_hold <= 1'b0;
          o_cpu_rst  <= 1'b0;
          if (w_ld) begin
            r_state     <= ARM;
            r_cnt       <= '0;
            o_load_done <= 1'b0;
            o_cpu_hold  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            o_checksum  <= '0;
`endif
          end
        end
        ARM: begin
          // A dropped LOAD_EN beats a same-cycle strobe edge.
          if (!w_ld) begin
            r_state   <= RELEASE;
            o_cpu_rst <= 1'b1;
          end else if (r_edge) begin
            r_state     <= WRITE;
            o_mem_we    <= 1'b1;
            o_mem_addr  <= r_cnt;
            o_mem_wdata <= i_data_in;
          end
        end
        WRITE: begin
          o_mem_we <= 1'b0;
          r_cnt    <= r_cnt + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          o_checksum <= o_checksum + o_mem_wdata;
`endif
          r_state  <= (r_cnt == '1) ? DRAIN : ARM;
        end
        DRAIN: begin
          if (!w_ld) begin
            r_state   <= RELEASE;
            o_cpu_rst <= 1'b1;
          end
        end
        RELEASE: begin
          o_cpu_rst   <= 1'b0;
          o_cpu_hold  <= 1'b0;
          o_load_done <= 1'b1;
          r_state     <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_sap1_prog_loader.sv
// Randomized bench for sap1_prog_loader against a session-level model.
// Define LOADER_CHECKSUM_EN to also check o_checksum.
module tb_sap1_prog_loader;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_en;
  logic       strobe;
  logic [7:0] din;
  logic       we;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       hold;
  logic       cpu_rst;
  logic       done;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] cks;
`endif

  sap1_prog_loader #(
    .ADDR_W(4),
    .DATA_W(8),
    .SYNC_STAGES(S)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load_en  (load_en),
    .i_strobe   (strobe),
    .i_data_in  (din),
    .o_mem_we   (we),
    .o_mem_addr (addr),
    .o_mem_wdata(wdata),
    .o_cpu_hold (hold),
    .o_cpu_rst  (cpu_rst),
    .o_load_done(done)
`ifdef LOADER_CHECKSUM_EN
    ,
    .o_checksum (cks)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] q_wr[$];
  int          n_cpu_rst = 0;
  logic [7:0]  fix[0:15];

  always @(negedge clk) begin
    if (!rst) begin
      if (we) q_wr.push_back({addr, wdata});
      if (cpu_rst) n_cpu_rst++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic session(input int n, input bit fixed, input bit lat);
    logic [7:0] exp[$];
    logic [7:0] sum;
    logic [7:0] d;
    int b0;
    int r0;
    sum = 8'h00;
    b0  = q_wr.size();
    r0  = n_cpu_rst;
    load_en = 1'b1;
    tick(6);
    chk("hold_armed", {31'b0, hold}, 1);
    chk("done_clr", {31'b0, done}, 0);
    for (int i = 0; i < n; i++) begin
      d = fixed ? fix[i] : 8'($urandom);
      if (i < 16) begin
        exp.push_back(d);
        sum = sum + d;
      end
      din    = d;
      strobe = 1'b1;
      if (lat && i == 0) begin
        tick(S + 1);
        chk("lat_early", {31'b0, we}, 0);
        tick(1);
        chk("lat_we", {31'b0, we}, 1);
        tick(1);
        chk("lat_width", {31'b0, we}, 0);
        tick(2);
      end else begin
        tick($urandom_range(4, 6));
      end
      strobe = 1'b0;
      tick($urandom_range(4, 6));
    end
    tick(8);
    chk("hold_loading", {31'b0, hold}, 1);
    load_en = 1'b0;
    tick(8);
    chk("n_writes", q_wr.size() - b0, exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (b0 + i < q_wr.size()) begin
        chk("wr_addr", {28'b0, q_wr[b0+i][11:8]}, i);
        chk("wr_data", {24'b0, q_wr[b0+i][7:0]}, {24'b0, exp[i]});
      end
    end
    chk("cpu_rst_pulses", n_cpu_rst - r0, 1);
    chk("done_set", {31'b0, done}, 1);
    chk("hold_run", {31'b0, hold}, 0);
    chk("we_idle", {31'b0, we}, 0);
`ifdef LOADER_CHECKSUM_EN
    chk("checksum", {24'b0, cks}, {24'b0, sum});
`endif
  endtask

  task automatic reset_mid();
    int b0;
    int r0;
    b0 = q_wr.size();
    load_en = 1'b1;
    tick(6);
    for (int i = 0; i < 5; i++) begin
      din    = 8'($urandom);
      strobe = 1'b1;
      tick(5);
      strobe = 1'b0;
      tick(5);
    end
    tick(4);
    chk("pre_rst_writes", q_wr.size() - b0, 5);
    r0  = n_cpu_rst;
    rst = 1'b1;
    #1;
    chk("rst_hold", {31'b0, hold}, 0);
    chk("rst_we", {31'b0, we}, 0);
    chk("rst_addr", {28'b0, addr}, 0);
    chk("rst_done", {31'b0, done}, 0);
    tick(2);
    load_en = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(4);
    chk("rst_no_cpu_rst", n_cpu_rst - r0, 0);
    chk("rst_run_hold", {31'b0, hold}, 0);
  endtask

  initial begin
    rst     = 1'b1;
    load_en = 1'b0;
    strobe  = 1'b0;
    din     = 8'h00;
    tick(3);
    chk("init_hold", {31'b0, hold}, 0);
    chk("init_we", {31'b0, we}, 0);
    chk("init_addr", {28'b0, addr}, 0);
    chk("init_done", {31'b0, done}, 0);
    chk("init_cpu_rst", {31'b0, cpu_rst}, 0);
    rst = 1'b0;
    tick(3);

    for (int i = 0; i < 16; i++) fix[i] = 8'h10 + 8'(i);
    session(16, 1'b1, 1'b0);

    fix[0] = 8'hAA;
    fix[1] = 8'hBB;
    fix[2] = 8'hCC;
    session(3, 1'b1, 1'b0);

    session(2, 1'b0, 1'b1);
    session(20, 1'b0, 1'b0);

    reset_mid();
    session(16, 1'b0, 1'b0);

    for (int k = 0; k < 4; k++) session($urandom_range(1, 18), 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    fix[0] = 8'hFF;
    fix[1] = 8'h02;
    fix[2] = 8'h03;
    session(3, 1'b1, 1'b0);
    chk("checksum_fixed", {24'b0, cks}, 32'h04);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
